// File: rtl/conv_stream_framer.sv
`default_nettype none
// ============================================================================
// Module  : conv_stream_framer
// Brief   : Re-frames the filtered pixel stream as AXI-Stream (user/last tags)
//           and admits exactly one frame per start command via a 2-entry skid.
// Rev     : 1.0  initial release
// ============================================================================
module conv_stream_framer #(
  parameter int PIXEL_SIZE    = 32,
  parameter int OUT_WIDTH     = 510,
  parameter int OUT_HEIGHT    = 510,
  parameter bit LAST_PER_LINE = 1'b0
) (
  input  logic                  axis_clk,
  input  logic                  axis_reset,
  input  logic                  i_start,
  input  logic                  i_s_data_valid,
  input  logic [PIXEL_SIZE-1:0] i_s_data,
  output logic                  o_s_ready,
  output logic                  o_m_data_valid,
  output logic [PIXEL_SIZE-1:0] o_m_data,
  output logic                  o_m_user,
  output logic                  o_m_last,
  input  logic                  i_m_ready,
  output logic                  o_busy,
  output logic                  o_frame_done
);

  localparam int COL_W   = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;
  localparam int ROW_W   = (OUT_HEIGHT > 1) ? $clog2(OUT_HEIGHT) : 1;
  localparam int ENTRY_W = PIXEL_SIZE + 2;

  localparam logic [COL_W-1:0] COL_MAX = COL_W'(OUT_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(OUT_HEIGHT - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]         state;
  logic [1:0]         state_next;
  logic [1:0]         occ;
  logic [COL_W-1:0]   col;
  logic [ROW_W-1:0]   row;
  logic [ENTRY_W-1:0] head;
  logic [ENTRY_W-1:0] tail;
  logic [ENTRY_W-1:0] in_entry;
  logic               s_ready_int;
  logic               accept;
  logic               pop;
  logic               at_col_end;
  logic               at_row_end;
  logic               beat_user;
  logic               beat_last;
  logic               frame_done_q;

  // Ready is built purely from registered state so it never sees i_m_ready.
  assign s_ready_int = (state == ST_RUN) && (occ != 2'd2);
  assign accept      = i_s_data_valid && s_ready_int;
  assign pop         = (occ != 2'd0) && i_m_ready;
  assign at_col_end  = (col == COL_MAX);
  assign at_row_end  = (row == ROW_MAX);
  assign beat_user   = (col == '0) && (row == '0);

  generate
    if (LAST_PER_LINE) begin : g_last_per_line
      assign beat_last = at_col_end;
    end else begin : g_last_per_frame
      assign beat_last = at_col_end && at_row_end;
    end
  endgenerate

  // Entry layout: {user, last, pixel}
  assign in_entry = {beat_user, beat_last, i_s_data};

  always_ff @(posedge axis_clk) begin
    if (axis_reset) begin
      state        <= ST_IDLE;
      frame_done_q <= 1'b0;
    end else begin
      state        <= state_next;
      frame_done_q <= (state == ST_DRAIN) && (state_next == ST_IDLE);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (i_start) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (accept && at_col_end && at_row_end) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Leave as soon as the last buffered beat is handed downstream.
        if ((occ == 2'd0) || ((occ == 2'd1) && pop)) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_s_ready      = s_ready_int;
    o_busy         = (state == ST_RUN) || (state == ST_DRAIN);
    o_frame_done   = frame_done_q;
    o_m_data_valid = (occ != 2'd0);
    o_m_data       = head[PIXEL_SIZE-1:0];
    o_m_last       = head[PIXEL_SIZE];
    o_m_user       = head[PIXEL_SIZE+1];
  end

  always_ff @(posedge axis_clk) begin
    if (axis_reset) begin
      col <= '0;
      row <= '0;
    end else if ((state == ST_IDLE) && i_start) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (at_col_end) begin
        col <= '0;
        row <= at_row_end ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  // Head always feeds the output; it is left untouched when the buffer empties
  // so the output bus holds its last value.
  always_ff @(posedge axis_clk) begin
    if (axis_reset) begin
      occ  <= 2'd0;
      head <= '0;
      tail <= '0;
    end else begin
      case ({accept, pop})
        2'b10: begin
          if (occ == 2'd0) head <= in_entry;
          else             tail <= in_entry;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          if (occ == 2'd2) head <= tail;
          occ <= occ - 2'd1;
        end
        2'b11: begin
          head <= in_entry;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_stream_framer.sv
`default_nettype none
// ============================================================================
// Module  : tb_conv_stream_framer
// Brief   : Scoreboard bench for conv_stream_framer (4x3 frames, both last modes).
// Rev     : 1.0  initial release
// ============================================================================
module tb_conv_stream_framer;

  localparam int P    = 32;
  localparam int W    = 4;
  localparam int H    = 3;
  localparam int NPIX = W * H;

  typedef struct packed {
    logic [P-1:0] data;
    logic         user;
    logic         last0;
    logic         last1;
    logic         fin;
  } item_t;

  logic              clk;
  logic              axis_reset;
  logic              i_start;
  logic              i_s_data_valid;
  logic [P-1:0]      i_s_data;
  logic              i_m_ready;
  logic [1:0]        s_ready;
  logic [1:0]        m_valid;
  logic [1:0][P-1:0] m_data;
  logic [1:0]        m_user;
  logic [1:0]        m_last;
  logic [1:0]        busy;
  logic [1:0]        frame_done;

  item_t q[$];
  logic  armed;
  logic  tmo;
  logic  rand_ready;
  logic  done_pending;
  logic  have_prev;
  logic  prev_stall;
  logic [1:0][P-1:0] p_data;
  logic [1:0]        p_user;
  logic [1:0]        p_last;
  int    rst_cnt;
  int    checks;
  int    errors;

  conv_stream_framer #(
    .PIXEL_SIZE(P), .OUT_WIDTH(W), .OUT_HEIGHT(H), .LAST_PER_LINE(1'b0)
  ) u_dut0 (
    .axis_clk(clk), .axis_reset(axis_reset), .i_start(i_start),
    .i_s_data_valid(i_s_data_valid), .i_s_data(i_s_data), .o_s_ready(s_ready[0]),
    .o_m_data_valid(m_valid[0]), .o_m_data(m_data[0]), .o_m_user(m_user[0]),
    .o_m_last(m_last[0]), .i_m_ready(i_m_ready), .o_busy(busy[0]),
    .o_frame_done(frame_done[0])
  );

  conv_stream_framer #(
    .PIXEL_SIZE(P), .OUT_WIDTH(W), .OUT_HEIGHT(H), .LAST_PER_LINE(1'b1)
  ) u_dut1 (
    .axis_clk(clk), .axis_reset(axis_reset), .i_start(i_start),
    .i_s_data_valid(i_s_data_valid), .i_s_data(i_s_data), .o_s_ready(s_ready[1]),
    .o_m_data_valid(m_valid[1]), .o_m_data(m_data[1]), .o_m_user(m_user[1]),
    .o_m_last(m_last[1]), .i_m_ready(i_m_ready), .o_busy(busy[1]),
    .o_frame_done(frame_done[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    i_m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      i_m_ready = rand_ready ? ($urandom_range(1) == 1) : 1'b1;
    end
  end

  task automatic chk(input string name, input int idx, input logic [P-1:0] act,
                     input logic [P-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, idx, act, exp, $time);
    end
  endtask

  // Monitor: the model's view is the queue of accepted-but-not-popped beats.
  initial begin
    done_pending = 1'b0;
    have_prev    = 1'b0;
    prev_stall   = 1'b0;
    rst_cnt      = 0;
    checks       = 0;
    errors       = 0;
  end

  always @(negedge clk) begin
    item_t hd;
    logic  ev;
    logic  er;
    logic  eb;
    logic  fin_q;
    if (axis_reset) begin
      q.delete();
      done_pending = 1'b0;
      have_prev    = 1'b0;
      rst_cnt++;
      if (rst_cnt >= 2) begin
        for (int i = 0; i < 2; i++) begin
          chk("rst_valid", i, P'(m_valid[i]), '0);
          chk("rst_data", i, m_data[i], '0);
          chk("rst_user", i, P'(m_user[i]), '0);
          chk("rst_last", i, P'(m_last[i]), '0);
          chk("rst_ready", i, P'(s_ready[i]), '0);
          chk("rst_busy", i, P'(busy[i]), '0);
          chk("rst_done", i, P'(frame_done[i]), '0);
        end
      end
    end else begin
      rst_cnt = 0;
      ev      = (q.size() > 0);
      er      = armed && (q.size() < 2);
      fin_q   = 1'b0;
      foreach (q[j]) if (q[j].fin) fin_q = 1'b1;
      eb      = armed || fin_q;
      chk("timeout", 0, P'(tmo), '0);
      for (int i = 0; i < 2; i++) begin
        chk("valid", i, P'(m_valid[i]), P'(ev));
        chk("s_ready", i, P'(s_ready[i]), P'(er));
        chk("busy", i, P'(busy[i]), P'(eb));
        chk("frame_done", i, P'(frame_done[i]), P'(done_pending));
        if (ev) begin
          hd = q[0];
          chk("data", i, m_data[i], hd.data);
          chk("user", i, P'(m_user[i]), P'(hd.user));
          chk("last", i, P'(m_last[i]), P'((i == 0) ? hd.last0 : hd.last1));
        end
        if (have_prev && prev_stall) begin
          chk("hold_data", i, m_data[i], p_data[i]);
          chk("hold_user", i, P'(m_user[i]), P'(p_user[i]));
          chk("hold_last", i, P'(m_last[i]), P'(p_last[i]));
        end
      end
      prev_stall   = ev && !i_m_ready;
      p_data       = m_data;
      p_user       = m_user;
      p_last       = m_last;
      have_prev    = 1'b1;
      done_pending = 1'b0;
      if (ev && i_m_ready) begin
        hd = q.pop_front();
        if (hd.fin) done_pending = 1'b1;
      end
    end
  end

  // Drive one frame; expected tags come from the beat index within the frame.
  task automatic run_frame(input bit seq, input int abort_at, input int gap_pct,
                           input bit start_mid);
    int    k;
    int    guard;
    bit    pulsed;
    bit    hs;
    item_t it;
    i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start        = 1'b0;
    armed          = 1'b1;
    k              = 0;
    guard          = 0;
    pulsed         = 1'b0;
    i_s_data_valid = 1'b0;
    while (k < NPIX && k != abort_at) begin
      if (!i_s_data_valid && ($urandom_range(99) >= gap_pct)) begin
        i_s_data_valid = 1'b1;
        i_s_data       = seq ? P'(k) : P'($urandom);
      end
      i_start = start_mid && !pulsed && (k == 6);
      if (i_start) pulsed = 1'b1;
      @(negedge clk);
      hs = i_s_data_valid && s_ready[0];
      @(posedge clk);
      #1;
      i_start = 1'b0;
      if (hs) begin
        it.data  = i_s_data;
        it.user  = (k == 0);
        it.last0 = (k == NPIX - 1);
        it.last1 = ((k % W) == W - 1);
        it.fin   = (k == NPIX - 1);
        q.push_back(it);
        k++;
        if (k == NPIX) armed = 1'b0;
        i_s_data_valid = 1'b0;
      end
      guard++;
      if (guard > 1000) begin
        tmo = 1'b1;
        break;
      end
    end
    i_s_data_valid = 1'b0;
    if (k == NPIX) begin
      // Start arriving while draining must be ignored.
      i_start = 1'b1;
      @(posedge clk);
      #1;
      i_start = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (q.size() != 0) begin
      @(posedge clk);
      #1;
      guard++;
      if (guard > 500) begin
        tmo = 1'b1;
        break;
      end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    axis_reset     = 1'b1;
    i_s_data_valid = 1'b0;
    i_start        = 1'b0;
    armed          = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    axis_reset = 1'b0;
  endtask

  initial begin
    axis_reset     = 1'b1;
    i_start        = 1'b0;
    i_s_data_valid = 1'b0;
    i_s_data       = '0;
    rand_ready     = 1'b0;
    armed          = 1'b0;
    tmo            = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    axis_reset = 1'b0;

    // Valid with no start: nothing may be accepted.
    i_s_data_valid = 1'b1;
    i_s_data       = 32'hdead_beef;
    repeat (5) @(posedge clk);
    #1;
    i_s_data_valid = 1'b0;

    run_frame(1'b1, -1, 0, 1'b0);
    wait_idle();

    // Beats offered after frame completion stay unaccepted.
    i_s_data_valid = 1'b1;
    i_s_data       = 32'h1234_5678;
    repeat (4) @(posedge clk);
    #1;
    i_s_data_valid = 1'b0;

    rand_ready = 1'b1;
    run_frame(1'b0, -1, 30, 1'b1);
    wait_idle();

    run_frame(1'b1, 5, 20, 1'b0);
    do_reset();

    run_frame(1'b1, -1, 0, 1'b0);
    wait_idle();

    for (int f = 0; f < 4; f++) begin
      run_frame(1'b0, -1, 40, f[0]);
      wait_idle();
    end

    rand_ready = 1'b0;
    run_frame(1'b0, -1, 0, 1'b0);
    wait_idle();

    @(negedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
